// File: rtl/servo_ramp_ctrl.sv
// rtl/servo_ramp_ctrl.sv - slew-rate-limited servo pulse-width sequencer with PWM output
module servo_ramp_ctrl #(
    parameter int unsigned FRAME_CYCLES = 1000000,
    parameter int unsigned MIN_PW       = 50000,
    parameter int unsigned MAX_PW       = 100000,
    parameter int unsigned STEP         = 500,
    parameter int unsigned W            = 32
) (
    input  logic         clock_clk,
    input  logic         reset_low,
    input  logic         enable,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_pw,
    output logic [W-1:0] cur_pw,
    output logic [W-1:0] target_pw,
    output logic         busy,
    output logic         done,
    output logic         cmd_clamped,
    output logic         frame_tick,
    output logic         pwm_out
);

    localparam logic [W-1:0] LAST_CNT = W'(FRAME_CYCLES - 1);
    localparam logic [W-1:0] MIN_V    = W'(MIN_PW);
    localparam logic [W-1:0] MAX_V    = W'(MAX_PW);
    localparam logic [W-1:0] STEP_V   = W'(STEP);
    localparam logic [W-1:0] MID_V    = W'((MIN_PW + MAX_PW) / 2);

    if (!(MIN_PW <= MAX_PW && MAX_PW < FRAME_CYCLES && STEP >= 1)) begin : g_param_check
        $error("servo_ramp_ctrl: illegal parameter set");
    end

    typedef enum logic {IDLE, RAMP} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] frame_cnt_q, frame_cnt_d;
    logic [W-1:0] cur_pw_q, cur_pw_d;
    logic [W-1:0] target_pw_q, target_pw_d;
    logic         done_q, done_d;
    logic         clamped_q, clamped_d;
    logic         pwm_q, pwm_d;
    logic         live_q;
    logic         accept;
    logic         ramp_up;
    logic [W-1:0] gap;
    logic [W-1:0] ramp_next;
    logic [W-1:0] cmd_clamp_val;

    assign frame_tick = (frame_cnt_q == LAST_CNT);
    // Commands are refused on the tick so a load never coincides with a ramp step.
    assign cmd_ready  = live_q && !frame_tick;
    assign accept     = cmd_valid && cmd_ready;

    assign cmd_clamp_val = (cmd_pw < MIN_V) ? MIN_V : ((cmd_pw > MAX_V) ? MAX_V : cmd_pw);

    assign ramp_up   = (target_pw_q > cur_pw_q);
    assign gap       = ramp_up ? (target_pw_q - cur_pw_q) : (cur_pw_q - target_pw_q);
    assign ramp_next = (gap > STEP_V) ? (ramp_up ? cur_pw_q + STEP_V : cur_pw_q - STEP_V)
                                      : target_pw_q;

    always_comb begin
        state_d     = state_q;
        cur_pw_d    = cur_pw_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_tick ? '0 : frame_cnt_q + W'(1);
        target_pw_d = accept ? cmd_clamp_val : target_pw_q;
        clamped_d   = accept && ((cmd_pw < MIN_V) || (cmd_pw > MAX_V));
        pwm_d       = enable && (frame_cnt_q < cur_pw_q);
        case (state_q)
            IDLE: begin
                if (target_pw_q != cur_pw_q) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (target_pw_q == cur_pw_q) begin
                    state_d = IDLE;
                    done_d  = enable;
                end else if (frame_tick && enable) begin
                    cur_pw_d = ramp_next;
                    if (ramp_next == target_pw_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            cur_pw_q    <= MID_V;
            target_pw_q <= MID_V;
            done_q      <= 1'b0;
            clamped_q   <= 1'b0;
            pwm_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            cur_pw_q    <= cur_pw_d;
            target_pw_q <= target_pw_d;
            done_q      <= done_d;
            clamped_q   <= clamped_d;
            pwm_q       <= pwm_d;
            live_q      <= 1'b1;
        end
    end

    assign cur_pw      = cur_pw_q;
    assign target_pw   = target_pw_q;
    assign busy        = (state_q == RAMP);
    assign done        = done_q;
    assign cmd_clamped = clamped_q;
    assign pwm_out     = pwm_q;

endmodule

// File: doc/servo_ramp_ctrl.md
Name: servo_ramp_ctrl

Overview:
Slew-rate-limited sequencer for one forklift servo channel. Accepts target pulse-width commands over a valid/ready handshake and clamps them to the legal range. It steps the live pulse width toward the target by at most STEP once per PWM frame, and generates the PWM output itself. All pulse-width changes occur on frame boundaries, so no output pulse is ever truncated or stretched mid-frame.

Parameters:
FRAME_CYCLES, 1000000, PWM period in clocks (20 ms at 50 MHz)
MIN_PW, 50000, minimum legal pulse width in clocks (1 ms)
MAX_PW, 100000, maximum legal pulse width in clocks (2 ms)
STEP, 500, maximum change of live pulse width per frame, in clocks
W, 32, width of counters and pulse-width buses

Ports:
clock_clk  in  1  system clock
reset_low  in  1  reset
enable  in  1  1 = drive PWM and advance ramp; 0 = output forced low, ramp frozen
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted this cycle
cmd_pw  in  W  requested target pulse width, in clocks
cur_pw  out  W  live pulse width applied to the current frame
target_pw  out  W  clamped target in force
busy  out  1  1 while cur_pw != target_pw
done  out  1  one-cycle pulse when cur_pw reaches target_pw
cmd_clamped  out  1  one-cycle pulse when an accepted command was out of range
frame_tick  out  1  one-cycle pulse on the last cycle of each frame
pwm_out  out  1  servo PWM

Behaviour:
- Reset: clock_clk, single clock domain; reset_low is asynchronous, active-low. While reset_low=0: frame_cnt=0, cur_pw=target_pw=MID, where MID=(MIN_PW+MAX_PW)/2 using integer division. Also pwm_out=0, busy=0, done=0, cmd_clamped=0, frame_tick=0, state=IDLE. cmd_ready=0 while reset is asserted.
- Frame counter:
  - frame_cnt increments each clock and wraps from FRAME_CYCLES-1 to 0. It runs regardless of enable.
  - frame_tick=1 combinationally when frame_cnt==FRAME_CYCLES-1.
- PWM generation:
  - pwm_out is registered: pwm_out <= enable && (frame_cnt < cur_pw).
  - With enable held high, pwm_out is high for exactly cur_pw consecutive cycles per frame, lagging frame_cnt by one cycle.
- Command handshake:
  - cmd_ready = 1 except on the frame_tick cycle, when it is 0.
  - A transfer occurs on cmd_valid && cmd_ready. The clamped value is loaded into target_pw on the next edge.
  - Clamp rule: values < MIN_PW become MIN_PW; values > MAX_PW become MAX_PW. cmd_clamped pulses with the load if either clamp applied.
  - A new command may replace target_pw at any time, including mid-ramp. The ramp redirects at the next frame boundary.
- State machine:
  - IDLE: cur_pw==target_pw.
  - RAMP: cur_pw!=target_pw. IDLE goes to RAMP on the edge after target_pw is loaded with a value different from cur_pw.
  - busy=1 exactly when in RAMP.
- Ramp update: on each frame_tick edge with enable=1, in RAMP:
  - if cur_pw<target_pw: cur_pw <= min(cur_pw+STEP, target_pw).
  - if cur_pw>target_pw: cur_pw <= max(cur_pw-STEP, target_pw).
  - Comparisons are done on differences, so no W-bit overflow occurs.
  - If the new cur_pw equals target_pw: state goes to IDLE and done pulses for one cycle.
- enable=0 behaviour: pwm_out goes to 0 on the next edge, cur_pw holds, commands are still accepted, and no done pulse is generated. Ramping resumes at the first frame_tick after enable returns to 1.
- Retarget to the current value: a command equal to cur_pw while in RAMP goes to IDLE on the next edge. done pulses on that same edge.
- Reset mid-ramp: all state returns to reset values immediately (asynchronous). pwm_out drops to 0 even mid-pulse.
- Parameter legality (checked in simulation only): MIN_PW <= MAX_PW < FRAME_CYCLES, and STEP >= 1.

Test Plan:
Bench parameters for all scenarios: FRAME_CYCLES=100, MIN_PW=10, MAX_PW=20, STEP=3, MID=15.
1. Reset release, enable=1, no commands -> cur_pw=15, busy=0, pwm_out high for exactly 15 cycles of every 100, rising one cycle after frame_cnt=0.
2. cmd_pw=20 accepted -> busy=1. At successive frame_ticks cur_pw goes 18 then 20. done pulses once with the second update, busy falls, and pulse widths in the next frames are 18 and then 20.
3. cmd_pw=5 -> target_pw=10 and cmd_clamped pulses. cur_pw goes 15, 12, 10 at successive frame_ticks, then done. Then cmd_pw=40 -> target_pw=20 and cmd_clamped pulses.
4. cmd_valid held high on the frame_tick cycle -> cmd_ready=0 and no transfer that cycle. The transfer occurs on the following cycle (frame_cnt=0).
5. Retarget mid-ramp: target 20 with cur_pw=18 after one frame, then cmd_pw=11 -> next frame cur_pw=15, then 12, then 11, then done. Exactly one done pulse occurs over the whole sequence.
6. enable=0 during a ramp for 3 frames -> pwm_out=0 and cur_pw frozen. On re-enable, the ramp continues from the frozen value. Separately, asserting reset_low=0 mid-pulse -> pwm_out=0 and cur_pw=15 with no clock edge required.
